// File: rtl/majority_pkg.sv
// Shared definitions for the triple-redundant majority voter.
//   state_t            : voter FSM states (IDLE, VOTE, OUT)
//   DEF_WIDTH          : default channel width
//   DEF_FAULT_THRESH   : default consecutive-mismatch count that marks a channel faulty
//   multi_fault()      : true when two or more channels are flagged faulty
package majority_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VOTE = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_FAULT_THRESH = 3;

    function automatic logic multi_fault(input logic [2:0] mask);
        return (mask[0] & mask[1]) | (mask[0] & mask[2]) | (mask[1] & mask[2]);
    endfunction

endpackage

// File: rtl/majority_bitwise.sv
// Combinational WIDTH-bit three-input bitwise majority.
// Ports:
//   a, b, c : input  [WIDTH-1:0]  operands
//   y       : output [WIDTH-1:0]  per-bit majority of a, b, c
module majority_bitwise #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/majority_vote_ctrl.sv
// Triple-redundant channel voter with per-channel fault tracking.
// A sample triple is accepted in IDLE, voted in VOTE (one cycle) and presented
// in OUT until the consumer takes it. Channels that disagree with the vote for
// FAULT_THRESH consecutive samples are flagged and excluded from later votes.
//
// Optional feature macro: MAJORITY_VOTE_STATS_EN
//   defined   -> vote_cnt / miss_cnt are 16-bit saturating statistics
//   undefined -> vote_cnt / miss_cnt tied to 0
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ch_a, ch_b, ch_c      : redundant channel samples
//   in_valid / in_ready   : sample handshake (ready only in IDLE)
//   out_valid / out_ready : result handshake, out_data holds the voted value
//   fault_clr             : clears fault_mask and mismatch counters
//   fault_mask            : sticky faulty flags, bit0=a, bit1=b, bit2=c
//   disagree              : last vote had no healthy majority
//   fatal                 : two or more channels faulty
//   vote_cnt, miss_cnt    : completed handshakes / disagreeing votes
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a sample triple, in_ready=1
// VOTE  | one cycle: register result, update fault tracking
// OUT   | out_valid=1, hold out_data until out_ready
module majority_vote_ctrl
    import majority_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int FAULT_THRESH = DEF_FAULT_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ch_a,
    input  logic [WIDTH-1:0] ch_b,
    input  logic [WIDTH-1:0] ch_c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             fault_clr,
    output logic [2:0]       fault_mask,
    output logic             disagree,
    output logic             fatal,
    output logic [15:0]      vote_cnt,
    output logic [15:0]      miss_cnt
);

    localparam logic [3:0] THRESH = 4'(FAULT_THRESH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] smp [3];
    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] vote;
    logic             vote_dis;
    logic [3:0]       cnt_q [3];
    logic [3:0]       cnt_d [3];
    logic             accept;

    majority_bitwise #(.WIDTH(WIDTH)) u_maj (
        .a (smp[0]),
        .b (smp[1]),
        .c (smp[2]),
        .y (maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_d = VOTE;
            end
            VOTE: state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && (state_q == IDLE);

    // With one faulty channel the lower-index healthy channel is the result
    // whether or not the healthy pair agrees; only disagree depends on equality.
    always_comb begin
        vote     = maj;
        vote_dis = 1'b0;
        case (fault_mask)
            3'b000: begin
                vote     = maj;
                vote_dis = 1'b0;
            end
            3'b001: begin
                vote     = smp[1];
                vote_dis = (smp[1] != smp[2]);
            end
            3'b010: begin
                vote     = smp[0];
                vote_dis = (smp[0] != smp[2]);
            end
            3'b100: begin
                vote     = smp[0];
                vote_dis = (smp[0] != smp[1]);
            end
            3'b101: begin
                vote     = smp[1];
                vote_dis = 1'b1;
            end
            3'b011: begin
                vote     = smp[2];
                vote_dis = 1'b1;
            end
            default: begin
                vote     = smp[0];
                vote_dis = 1'b1;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = 4'd0;
            if (smp[i] != vote) cnt_d[i] = (cnt_q[i] >= THRESH) ? cnt_q[i] : cnt_q[i] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) smp[i] <= '0;
            out_data <= '0;
            disagree <= 1'b0;
        end else begin
            if (accept) begin
                smp[0] <= ch_a;
                smp[1] <= ch_b;
                smp[2] <= ch_c;
            end
            if (state_q == VOTE) begin
                out_data <= vote;
                disagree <= vote_dis;
            end
        end
    end

    // fault_clr takes priority so a threshold hit in the same cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= 4'd0;
            fault_mask <= 3'b000;
        end else if (fault_clr) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= 4'd0;
            fault_mask <= 3'b000;
        end else if (state_q == VOTE) begin
            for (int i = 0; i < 3; i++) begin
                if (!fault_mask[i]) begin
                    cnt_q[i] <= cnt_d[i];
                    if (cnt_d[i] >= THRESH) fault_mask[i] <= 1'b1;
                end
            end
        end
    end

    assign fatal = multi_fault(fault_mask);

`ifdef MAJORITY_VOTE_STATS_EN
    logic [15:0] vote_q, miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 16'd0;
            miss_q <= 16'd0;
        end else begin
            if (state_q == OUT && out_ready && vote_q != 16'hFFFF) vote_q <= vote_q + 16'd1;
            if (state_q == VOTE && vote_dis && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

    assign vote_cnt = vote_q;
    assign miss_cnt = miss_q;
`else
    assign vote_cnt = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// Directed bench for majority_vote_ctrl. Inputs change on the falling edge,
// outputs are checked on the falling edge (or shortly after an async event).
module tb_majority_vote_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ch_a, ch_b, ch_c;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        fault_clr;
    logic [2:0]  fault_mask;
    logic        disagree, fatal;
    logic [15:0] vote_cnt, miss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    majority_vote_ctrl #(.WIDTH(8), .FAULT_THRESH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_a       (ch_a),
        .ch_b       (ch_b),
        .ch_c       (ch_c),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fault_clr  (fault_clr),
        .fault_mask (fault_mask),
        .disagree   (disagree),
        .fatal      (fatal),
        .vote_cnt   (vote_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called on a falling edge with the DUT idle; returns on a falling edge
    // with the DUT idle again.
    task automatic do_vote(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] exp_d,
                           input logic exp_dis, input int stall);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        ch_a = a; ch_b = b; ch_c = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_vote_no_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, "_disagree"}, 32'(disagree), 32'(exp_dis));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_data"}, 32'(out_data), 32'(exp_d));
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int exp_vc, exp_mc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fault_clr = 1'b0;
        ch_a = 8'h00; ch_b = 8'h00; ch_c = 8'h00;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_mask", 32'(fault_mask), 32'd0);
        chk("rst_fatal", 32'(fatal), 32'd0);
        chk("rst_disagree", 32'(disagree), 32'd0);
        chk("rst_vote_cnt", 32'(vote_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Plain majority; c is the odd one out three times in a row.
        do_vote("maj1", 8'h0F, 8'h0F, 8'hF0, 8'h0F, 1'b0, 0);
        chk("maj1_mask", 32'(fault_mask), 32'd0);
        do_vote("maj2", 8'h11, 8'h11, 8'h22, 8'h11, 1'b0, 0);
        chk("maj2_mask", 32'(fault_mask), 32'd0);
        do_vote("maj3", 8'h33, 8'h33, 8'h44, 8'h33, 1'b0, 0);
        chk("maj3_mask", 32'(fault_mask), 32'b100);
        chk("maj3_fatal", 32'(fatal), 32'd0);

        // c excluded; healthy pair disagrees -> lower index wins.
        do_vote("excl", 8'h11, 8'h22, 8'h99, 8'h11, 1'b1, 0);
        // Backpressure: b matches here, resetting its counter.
        do_vote("stall", 8'h55, 8'h55, 8'h00, 8'h55, 1'b0, 5);

        // Drive b faulty as well.
        do_vote("bf1", 8'h01, 8'h02, 8'h00, 8'h01, 1'b1, 0);
        do_vote("bf2", 8'h03, 8'h04, 8'h00, 8'h03, 1'b1, 0);
        chk("bf2_mask", 32'(fault_mask), 32'b100);
        do_vote("bf3", 8'h05, 8'h06, 8'h00, 8'h05, 1'b1, 0);
        chk("bf3_mask", 32'(fault_mask), 32'b110);
        chk("bf3_fatal", 32'(fatal), 32'd1);
        do_vote("fatal", 8'hAA, 8'hBB, 8'hCC, 8'hAA, 1'b1, 0);

        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_mask", 32'(fault_mask), 32'd0);
        chk("clr_fatal", 32'(fatal), 32'd0);
        do_vote("post_clr", 8'h0F, 8'hF0, 8'hF0, 8'hF0, 1'b0, 0);

        // Reset while a result is being presented.
        ch_a = 8'h77; ch_b = 8'h77; ch_c = 8'h77; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rel_no_valid", 32'(out_valid), 32'd0);
            chk("mid_rel_idle", 32'(in_ready), 32'd1);
        end

        // Statistics: four votes, only the last disagrees.
        chk("stat0_vote_cnt", 32'(vote_cnt), 32'd0);
        do_vote("st1", 8'h10, 8'h10, 8'h01, 8'h10, 1'b0, 0);
        do_vote("st2", 8'h20, 8'h20, 8'h02, 8'h20, 1'b0, 0);
        do_vote("st3", 8'h30, 8'h30, 8'h03, 8'h30, 1'b0, 0);
        chk("st3_mask", 32'(fault_mask), 32'b100);
        do_vote("st4", 8'h40, 8'h41, 8'h04, 8'h40, 1'b1, 0);
`ifdef MAJORITY_VOTE_STATS_EN
        exp_vc = 4; exp_mc = 1;
`else
        exp_vc = 0; exp_mc = 0;
`endif
        chk("stat_vote_cnt", 32'(vote_cnt), 32'(exp_vc));
        chk("stat_miss_cnt", 32'(miss_cnt), 32'(exp_mc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/majority_vote_ctrl.md
MAJORITY_VOTE_CTRL -- requirements
Module: majority_vote_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each redundant channel.
REQ-002 SHALL have parameter FAULT_THRESH, default 3, consecutive per-channel mismatches that mark a channel faulty (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports ch_a, ch_b, ch_c  input  WIDTH  redundant channel samples.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1: sample handshake.
REQ-007 SHALL have ports out_valid output 1 / out_ready input 1 / out_data output WIDTH: result handshake.
REQ-008 SHALL have port fault_clr  input  1  clears fault_mask and mismatch counters.
REQ-009 SHALL have port fault_mask  output  3  sticky faulty flags, bit0=a, bit1=b, bit2=c.
REQ-010 SHALL have port disagree  output  1  last vote had no healthy majority.
REQ-011 SHALL have port fatal  output  1  two or more channels faulty.
REQ-012 SHALL have ports vote_cnt, miss_cnt  output  16  statistics (see Configuration).

Function
REQ-013 SHALL implement FSM IDLE -> VOTE -> OUT -> IDLE; in_ready=1 only in IDLE.
REQ-014 SHALL capture ch_a/b/c in IDLE when in_valid&&in_ready, move to VOTE.
REQ-015 SHALL in VOTE (one cycle) register out_data and update counters, then enter OUT.
REQ-016 SHALL hold out_valid=1 and out_data stable in OUT until out_ready=1, then return to IDLE; latency accept-to-out_valid = 2 cycles; max throughput 1 sample per 3 cycles.
REQ-017 SHALL with fault_mask=000 output bitwise majority of the three channels; disagree=0.
REQ-018 SHALL with exactly one channel faulty exclude it: healthy pair equal -> that value, disagree=0; unequal -> lower-index healthy channel, disagree=1.
REQ-019 SHALL with two or more faulty output lowest-index healthy channel (ch_a if none), fatal=1, disagree=1.
REQ-020 SHALL per healthy channel increment a 4-bit mismatch counter when its sample differs from out_data, clear it on match, saturate at FAULT_THRESH.
REQ-021 SHALL set fault_mask bit in the VOTE cycle where its counter reaches FAULT_THRESH; bit stays set until fault_clr or reset.
REQ-022 SHALL on fault_clr=1 zero fault_mask and counters next edge in any state without disturbing the handshake; fault_clr wins over a simultaneous threshold hit.
REQ-023 SHALL not update counters for channels already faulty.

Reset
REQ-024 SHALL on rst_n=0 immediately force state IDLE, in_ready=0, out_valid=0, out_data=0, fault_mask=0, disagree=0, fatal=0, counters=0; in_ready=1 first cycle after release.
REQ-025 SHALL discard any in-flight transaction on reset mid-operation; no out_valid is produced for it.

Configuration
REQ-026 SHALL with MAJORITY_VOTE_STATS_EN defined count completed output handshakes in vote_cnt and disagree=1 votes in miss_cnt, both 16-bit saturating, cleared by reset only.
REQ-027 SHALL without MAJORITY_VOTE_STATS_EN keep ports vote_cnt and miss_cnt, tied to 0, no counter logic.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, VOTE, OUT), default WIDTH and FAULT_THRESH constants in shared package majority_pkg.
REQ-029 SHALL instantiate combinational sub-module majority_bitwise (WIDTH-bit three-input majority) for REQ-017.

Verification
REQ-030 SHALL cover: a=8'h0F,b=8'h0F,c=8'hF0 -> out_data=8'h0F two cycles after accept, disagree=0, mask=000.
REQ-031 SHALL cover: c differs from the vote 3 consecutive samples -> fault_mask=100 after 3rd VOTE; then a=8'h11,b=8'h22 -> out_data=8'h11, disagree=1.
REQ-032 SHALL cover: out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover: faults on b and c -> fatal=1, out_data=ch_a; fault_clr pulse -> mask=000, fatal=0.
REQ-034 SHALL cover: rst_n=0 during OUT -> out_valid=0 immediately, no result after release, in_ready=1.
REQ-035 SHALL cover: with MAJORITY_VOTE_STATS_EN, 4 votes incl. 1 disagree -> vote_cnt=4, miss_cnt=1; without it both read 0.
